mod_swapchain_timer: RTL and testbench

- Modulation sampling-index generator with two-segment swapchain.
- Sits between the control-register bank and the modulation BRAM reader.
- Consumes per-segment CYCLE/FREQ_DIV/REP settings, latched on a CTL_FLAG_MOD_SET update pulse, and the requested read segment.
- Produces the active SEGMENT and sample IDX that address modulation memory, plus a STOP flag when a finite-repeat segment finishes.

---
 rtl/mod_swapchain_timer.sv | 165 ++++++++++++++++
 tb/tb_mod_swapchain_timer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mod_swapchain_timer.sv
// Modulation sample-index generator with a two-segment swapchain and finite/infinite repeat.
// Optional debug port LOOP_CNT is enabled by defining MOD_SWAPCHAIN_LOOP_CNT_OUT_EN.
module mod_swapchain_timer #(
  parameter int IDX_WIDTH = 15,
  parameter int DIV_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TICK,
  input  logic                 UPDATE,
  input  logic                 REQ_RD_SEGMENT,
  input  logic [IDX_WIDTH-1:0] CYCLE_0,
  input  logic [IDX_WIDTH-1:0] CYCLE_1,
  input  logic [DIV_WIDTH-1:0] FREQ_DIV_0,
  input  logic [DIV_WIDTH-1:0] FREQ_DIV_1,
  input  logic [DIV_WIDTH-1:0] REP_0,
  input  logic [DIV_WIDTH-1:0] REP_1,
`ifdef MOD_SWAPCHAIN_LOOP_CNT_OUT_EN
  output logic [DIV_WIDTH-1:0] LOOP_CNT,
`endif
  output logic                 SEGMENT,
  output logic [IDX_WIDTH-1:0] IDX,
  output logic                 IDX_VALID,
  output logic                 STOP
);

  typedef enum logic [1:0] {ST_INF, ST_WAIT, ST_FIN, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic                 seg_q, seg_d;
  logic                 pend_q, pend_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 stop_q, stop_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
  logic [IDX_WIDTH-1:0] cycle_q [2];
  logic [IDX_WIDTH-1:0] cycle_d [2];
  logic [DIV_WIDTH-1:0] div_q [2];
  logic [DIV_WIDTH-1:0] div_d [2];
  logic [DIV_WIDTH-1:0] rep_q [2];
  logic [DIV_WIDTH-1:0] rep_d [2];

  logic [IDX_WIDTH-1:0] cur_cycle;
  logic [DIV_WIDTH-1:0] cur_div;
  logic [DIV_WIDTH-1:0] cur_rep;
  logic [DIV_WIDTH-1:0] tgt_rep;
  logic                 wrap;
  logic                 div_hit;

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    valid_d    = 1'b0;
    stop_d     = stop_q;
    div_cnt_d  = div_cnt_q;
    loop_cnt_d = loop_cnt_q;
    cycle_d    = cycle_q;
    div_d      = div_q;
    rep_d      = rep_q;

    cur_cycle = cycle_q[seg_q];
    cur_div   = div_q[seg_q];
    cur_rep   = rep_q[seg_q];
    tgt_rep   = REQ_RD_SEGMENT ? REP_1 : REP_0;
    wrap      = (idx_q == cur_cycle);
    // Stored dividers are never zero, so div-1 cannot underflow.
    div_hit   = (div_cnt_q == cur_div - 1'b1);

    if (UPDATE) begin
      cycle_d[0] = CYCLE_0;
      cycle_d[1] = CYCLE_1;
      div_d[0]   = (FREQ_DIV_0 == '0) ? DIV_WIDTH'(1) : FREQ_DIV_0;
      div_d[1]   = (FREQ_DIV_1 == '0) ? DIV_WIDTH'(1) : FREQ_DIV_1;
      rep_d[0]   = REP_0;
      rep_d[1]   = REP_1;
      if ((&tgt_rep) || (state_q == ST_DONE)) begin
        seg_d      = REQ_RD_SEGMENT;
        idx_d      = '0;
        div_cnt_d  = '0;
        loop_cnt_d = '0;
        stop_d     = 1'b0;
        valid_d    = 1'b1;
        state_d    = (&tgt_rep) ? ST_INF : ST_FIN;
      end else begin
        // Finite target while running: the current segment finishes its cycle first.
        pend_d  = REQ_RD_SEGMENT;
        state_d = ST_WAIT;
      end
    end else if (TICK && (state_q != ST_DONE)) begin
      if (!div_hit) begin
        div_cnt_d = div_cnt_q + 1'b1;
      end else begin
        div_cnt_d = '0;
        valid_d   = 1'b1;
        idx_d     = wrap ? '0 : idx_q + 1'b1;
        case (state_q)
          ST_WAIT: begin
            if (wrap) begin
              seg_d      = pend_q;
              loop_cnt_d = '0;
              state_d    = ST_FIN;
            end
          end
          ST_FIN: begin
            if (wrap) begin
              if (loop_cnt_q == cur_rep) begin
                idx_d   = idx_q;
                valid_d = 1'b0;
                stop_d  = 1'b1;
                state_d = ST_DONE;
              end else begin
                loop_cnt_d = loop_cnt_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_INF;
      seg_q      <= 1'b0;
      pend_q     <= 1'b0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      stop_q     <= 1'b0;
      div_cnt_q  <= '0;
      loop_cnt_q <= '0;
      cycle_q[0] <= '0;
      cycle_q[1] <= '0;
      div_q[0]   <= DIV_WIDTH'(1);
      div_q[1]   <= DIV_WIDTH'(1);
      rep_q[0]   <= '1;
      rep_q[1]   <= '1;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      stop_q     <= stop_d;
      div_cnt_q  <= div_cnt_d;
      loop_cnt_q <= loop_cnt_d;
      cycle_q    <= cycle_d;
      div_q      <= div_d;
      rep_q      <= rep_d;
    end
  end

  assign SEGMENT   = seg_q;
  assign IDX       = idx_q;
  assign IDX_VALID = valid_q;
  assign STOP      = stop_q;

`ifdef MOD_SWAPCHAIN_LOOP_CNT_OUT_EN
  assign LOOP_CNT = ((state_q == ST_FIN) || (state_q == ST_DONE)) ? loop_cnt_q : '0;
`endif

endmodule

// File: tb/tb_mod_swapchain_timer.sv
// Directed self-checking bench for mod_swapchain_timer.
module tb_mod_swapchain_timer;
  localparam int IW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          update = 1'b0;
  logic          req = 1'b0;
  logic [IW-1:0] cycle0 = '0, cycle1 = '0;
  logic [DW-1:0] fdiv0 = '0, fdiv1 = '0, rep0 = '0, rep1 = '0;
  logic          segment, idx_valid, stop;
  logic [IW-1:0] idx;
`ifdef MOD_SWAPCHAIN_LOOP_CNT_OUT_EN
  logic [DW-1:0] loop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int t1_idx [8]  = '{1, 2, 3, 0, 1, 2, 3, 0};
  int t2_seg [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  int t2_idx [12] = '{1, 2, 2, 3, 3, 0, 1, 0, 1, 1, 1, 1};
  int t2_vld [12] = '{0, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0};
  int t2_stp [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

  always #5 clk = ~clk;

  mod_swapchain_timer #(.IDX_WIDTH(IW), .DIV_WIDTH(DW)) dut (
    .CLK(clk),
    .RST(rst),
    .TICK(tick),
    .UPDATE(update),
    .REQ_RD_SEGMENT(req),
    .CYCLE_0(cycle0),
    .CYCLE_1(cycle1),
    .FREQ_DIV_0(fdiv0),
    .FREQ_DIV_1(fdiv1),
    .REP_0(rep0),
    .REP_1(rep1),
`ifdef MOD_SWAPCHAIN_LOOP_CNT_OUT_EN
    .LOOP_CNT(loop_cnt),
`endif
    .SEGMENT(segment),
    .IDX(idx),
    .IDX_VALID(idx_valid),
    .STOP(stop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t, input logic u);
    @(negedge clk);
    tick   = t;
    update = u;
    @(posedge clk);
    #1;
    tick   = 1'b0;
    update = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", 32'(segment), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_vld", 32'(idx_valid), 0);
    chk("rst_stop", 32'(stop), 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: infinite segment 0, cycle 3, divide by 2
    req = 1'b0; cycle0 = 15'd3; fdiv0 = 32'd2; rep0 = '1;
    step(1'b0, 1'b1);
    chk("t1_upd_idx", 32'(idx), 0);
    chk("t1_upd_vld", 32'(idx_valid), 1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0);
      chk("t1_vld", 32'(idx_valid), 32'(i % 2));
      if (i % 2 == 1) chk("t1_idx", 32'(idx), 32'(t1_idx[i / 2]));
      chk("t1_seg", 32'(segment), 0);
      chk("t1_stop", 32'(stop), 0);
    end

    // Test 2: move to IDX=1, then queue finite segment 1
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("t2_pre_idx", 32'(idx), 1);
    req = 1'b1; cycle1 = 15'd1; fdiv1 = 32'd1; rep1 = 32'd1;
    step(1'b0, 1'b1);
    chk("t2_upd_seg", 32'(segment), 0);
    chk("t2_upd_idx", 32'(idx), 1);
    chk("t2_upd_vld", 32'(idx_valid), 0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      chk("t2_seg", 32'(segment), 32'(t2_seg[i]));
      chk("t2_idx", 32'(idx), 32'(t2_idx[i]));
      chk("t2_vld", 32'(idx_valid), 32'(t2_vld[i]));
      chk("t2_stop", 32'(stop), 32'(t2_stp[i]));
    end

    // Test 3: from DONE, finite segment 0 starts immediately
    req = 1'b0; cycle0 = 15'd2; fdiv0 = 32'd1; rep0 = 32'd0;
    step(1'b0, 1'b1);
    chk("t3_seg", 32'(segment), 0);
    chk("t3_idx0", 32'(idx), 0);
    chk("t3_stop0", 32'(stop), 0);
    chk("t3_vld0", 32'(idx_valid), 1);
    step(1'b1, 1'b0);
    chk("t3_idx1", 32'(idx), 1);
    step(1'b1, 1'b0);
    chk("t3_idx2", 32'(idx), 2);
    chk("t3_stop2", 32'(stop), 0);
    step(1'b1, 1'b0);
    chk("t3_hold_idx", 32'(idx), 2);
    chk("t3_hold_vld", 32'(idx_valid), 0);
    chk("t3_hold_stop", 32'(stop), 1);
    step(1'b1, 1'b0);
    chk("t3_hold2_idx", 32'(idx), 2);
    chk("t3_hold2_vld", 32'(idx_valid), 0);

    // Test 4: UPDATE coincident with divider-completing TICK
    req = 1'b0; cycle0 = 15'd3; fdiv0 = 32'd3; rep0 = '1;
    step(1'b0, 1'b1);
    chk("t4_start_stop", 32'(stop), 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("t4_pre_idx", 32'(idx), 0);
    step(1'b1, 1'b1);
    chk("t4_idx", 32'(idx), 0);
    chk("t4_vld", 32'(idx_valid), 1);
    step(1'b0, 1'b0);
    chk("t4_vld_once", 32'(idx_valid), 0);
    chk("t4_idx_hold", 32'(idx), 0);
    step(1'b1, 1'b0);
    chk("t4_div1_idx", 32'(idx), 0);
    step(1'b1, 1'b0);
    chk("t4_div2_idx", 32'(idx), 0);
    step(1'b1, 1'b0);
    chk("t4_adv_idx", 32'(idx), 1);
    chk("t4_adv_vld", 32'(idx_valid), 1);

    // Test 5: FREQ_DIV of zero acts as one
    cycle0 = 15'd3; fdiv0 = 32'd0; rep0 = '1;
    step(1'b0, 1'b1);
    chk("t5_idx0", 32'(idx), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk("t5_idx", 32'(idx), 32'((i + 1) % 4));
      chk("t5_vld", 32'(idx_valid), 1);
    end

    // Test 6: asynchronous reset while a finite swap is pending
    req = 1'b1; cycle1 = 15'd1; fdiv1 = 32'd1; rep1 = 32'd0;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("t6_wait_seg", 32'(segment), 0);
    chk("t6_wait_idx", 32'(idx), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_idx", 32'(idx), 0);
    chk("t6_rst_seg", 32'(segment), 0);
    chk("t6_rst_vld", 32'(idx_valid), 0);
    chk("t6_rst_stop", 32'(stop), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("t6_post_idx", 32'(idx), 0);
      chk("t6_post_seg", 32'(segment), 0);
      chk("t6_post_stop", 32'(stop), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
